// File: rtl/btb_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Fetch reads the prediction combinationally; EX/MEM resolves and trains.

module btb_entry #(
  parameter int         ADDR_W   = 32,
  parameter int         TAG_W    = 26,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              sel,
  input  logic              upd_taken,
  input  logic [TAG_W-1:0]  upd_tag,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [ADDR_W-1:0] target,
  output logic [1:0]        ctr
);

  logic tag_hit;

  assign tag_hit = valid && (tag == upd_tag);

  // Flush wins over training; tag/target are left stale since valid gates them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      ctr    <= CTR_INIT;
    end else if (flush) begin
      valid <= 1'b0;
      ctr   <= CTR_INIT;
    end else if (sel) begin
      if (tag_hit) begin
        if (upd_taken) begin
          target <= upd_target;
          if (ctr != 2'b11) ctr <= ctr + 2'b01;
        end else if (ctr != 2'b00) begin
          ctr <= ctr - 2'b01;
        end
      end else if (upd_taken) begin
        valid  <= 1'b1;
        tag    <= upd_tag;
        target <= upd_target;
        ctr    <= 2'b10;
      end
    end
  end

endmodule

module btb_branch_predictor #(
  parameter int         ADDR_W   = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_npc,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_npc,
  input  logic              flush,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0]             valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag;
  logic [ENTRIES-1:0][ADDR_W-1:0] target;
  logic [ENTRIES-1:0][1:0]        ctr;
  logic [ENTRIES-1:0]             upd_sel;

  logic [IDX_W-1:0] fetch_idx, upd_idx;
  logic [TAG_W-1:0] fetch_tag, upd_tag;
  logic             fetch_hit, wrong;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign fetch_tag = fetch_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_tag   = upd_pc[ADDR_W-1:IDX_W+2];

  always_comb begin
    upd_sel = '0;
    for (int i = 0; i < ENTRIES; i++)
      upd_sel[i] = upd_en && (upd_idx == IDX_W'(i));
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    btb_entry #(
      .ADDR_W  (ADDR_W),
      .TAG_W   (TAG_W),
      .CTR_INIT(CTR_INIT)
    ) u_entry (
      .clk       (CLK),
      .rst_n     (nRST),
      .flush     (flush),
      .sel       (upd_sel[i]),
      .upd_taken (upd_taken),
      .upd_tag   (upd_tag),
      .upd_target(upd_target),
      .valid     (valid[i]),
      .tag       (tag[i]),
      .target    (target[i]),
      .ctr       (ctr[i])
    );
  end

  // Lookup sees pre-update state; a same-cycle write shows up next cycle.
  assign fetch_hit  = valid[fetch_idx] && (tag[fetch_idx] == fetch_tag);
  assign pred_taken = fetch_hit && ctr[fetch_idx][1];
  assign pred_npc   = pred_taken ? target[fetch_idx] : fetch_pc + ADDR_W'(4);

  assign wrong = upd_en && ((upd_taken != upd_pred_taken) ||
                            (upd_taken && (upd_target != upd_pred_npc)));

  // Detection and the counter are independent of flush.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mispredict     <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
    end else begin
      mispredict <= wrong;
      if (wrong) begin
        redirect_pc <= upd_taken ? upd_target : upd_pc + ADDR_W'(4);
        if (mispredict_cnt != {CNT_W{1'b1}}) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Bench for btb_branch_predictor: directed vector table, reset corner, random vs model.
module tb_btb_branch_predictor;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_npc = '0;
  logic        flush = 1'b0;

  logic        pred_taken, pred_taken2;
  logic [31:0] pred_npc, pred_npc2;
  logic        mispredict, mispredict2;
  logic [31:0] redirect_pc, redirect_pc2;
  logic [15:0] mispredict_cnt;
  logic [1:0]  mispredict_cnt2;

  always #5 CLK = ~CLK;

  btb_branch_predictor u_dut (
    .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_npc(pred_npc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc), .flush(flush),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
  );

  btb_branch_predictor #(.CNT_W(2)) u_dut2 (
    .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc), .pred_taken(pred_taken2), .pred_npc(pred_npc2),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc), .flush(flush),
    .mispredict(mispredict2), .redirect_pc(redirect_pc2), .mispredict_cnt(mispredict_cnt2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: 16 entries keyed by word index, tag is pc / 64.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_cnt, m_cnt2;
  bit          m_mis;
  logic [31:0] m_redir;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_cnt = 0; m_cnt2 = 0; m_mis = 0; m_redir = '0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] npc);
    int idx;
    idx = int'((pc / 4) % 16);
    t   = m_valid[idx] && (m_tag[idx] == pc / 64) && (m_ctr[idx] >= 2);
    npc = t ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic void m_step(input bit ue, input logic [31:0] up, input bit ut,
                                 input logic [31:0] utg, input bit upt, input logic [31:0] upn,
                                 input bit fl);
    int idx;
    bit wr;
    idx = int'((up / 4) % 16);
    wr  = ue && ((ut != upt) || (ut && utg != upn));
    m_mis = wr;
    if (wr) begin
      m_redir = ut ? utg : up + 32'd4;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (fl) begin
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_ctr[i] = 1; end
    end else if (ue) begin
      if (m_valid[idx] && m_tag[idx] == up / 64) begin
        if (ut) begin m_tgt[idx] = utg; m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1; end
        else m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
      end else if (ut) begin
        m_valid[idx] = 1; m_tag[idx] = up / 64; m_tgt[idx] = utg; m_ctr[idx] = 2;
      end
    end
  endfunction

  task automatic drive(input logic [31:0] f, input bit ue, input logic [31:0] up, input bit ut,
                       input logic [31:0] utg, input bit upt, input logic [31:0] upn, input bit fl);
    @(negedge CLK);
    fetch_pc = f; upd_en = ue; upd_pc = up; upd_taken = ut; upd_target = utg;
    upd_pred_taken = upt; upd_pred_npc = upn; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    m_step(upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_npc, flush);
    #1;
  endtask

  typedef struct {
    logic [31:0] f;
    bit          ue;
    logic [31:0] up;
    bit          ut;
    logic [31:0] utg;
    bit          upt;
    logic [31:0] upn;
    bit          fl;
    bit          ept;
    logic [31:0] enpc;
    bit          emis;
    logic [31:0] ered;
    int          ecnt;
  } vec_t;

  function automatic vec_t mk(input int f, input int ue, input int up, input int ut, input int utg,
                              input int upt, input int upn, input int fl, input int ept,
                              input int enpc, input int emis, input int ered, input int ecnt);
    vec_t v;
    v.f = 32'(f); v.ue = (ue != 0); v.up = 32'(up); v.ut = (ut != 0); v.utg = 32'(utg);
    v.upt = (upt != 0); v.upn = 32'(upn); v.fl = (fl != 0); v.ept = (ept != 0);
    v.enpc = 32'(enpc); v.emis = (emis != 0); v.ered = 32'(ered); v.ecnt = ecnt;
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    bit          t;
    logic [31:0] npc, f, up, utg, upn;
    bit          ue, ut, upt, fl;

    //           fetch       ue up       ut tgt      pt npc      fl  ept enpc      mis red     cnt
    tbl[0]  = mk(32'h40,     0, 0,       0, 0,       0, 0,       0,  0, 32'h44,    0, 0,       0);
    tbl[1]  = mk(32'h40,     1, 32'h40,  1, 32'h100, 0, 32'h44,  0,  0, 32'h44,    1, 32'h100, 1);
    tbl[2]  = mk(32'h40,     0, 0,       0, 0,       0, 0,       0,  1, 32'h100,   0, 32'h100, 1);
    tbl[3]  = mk(32'h40,     1, 32'h40,  1, 32'h100, 1, 32'h100, 0,  1, 32'h100,   0, 32'h100, 1);
    tbl[4]  = mk(32'h40,     1, 32'h40,  1, 32'h100, 1, 32'h100, 0,  1, 32'h100,   0, 32'h100, 1);
    tbl[5]  = mk(32'h40,     1, 32'h40,  0, 32'h100, 1, 32'h100, 0,  1, 32'h100,   1, 32'h44,  2);
    tbl[6]  = mk(32'h40,     1, 32'h40,  0, 32'h100, 1, 32'h100, 0,  1, 32'h100,   1, 32'h44,  3);
    tbl[7]  = mk(32'h40,     1, 32'h40,  0, 32'h100, 0, 32'h44,  0,  0, 32'h44,    0, 32'h44,  3);
    tbl[8]  = mk(32'h40,     1, 32'h40,  1, 32'h100, 0, 32'h44,  0,  0, 32'h44,    1, 32'h100, 4);
    tbl[9]  = mk(32'h40,     0, 0,       0, 0,       0, 0,       0,  0, 32'h44,    0, 32'h100, 4);
    tbl[10] = mk(32'h80,     1, 32'h80,  1, 32'h200, 0, 32'h84,  0,  0, 32'h84,    1, 32'h200, 5);
    tbl[11] = mk(32'h40,     0, 0,       0, 0,       0, 0,       0,  0, 32'h44,    0, 32'h200, 5);
    tbl[12] = mk(32'h80,     0, 0,       0, 0,       0, 0,       0,  1, 32'h200,   0, 32'h200, 5);
    tbl[13] = mk(32'h80,     1, 32'hC0,  1, 32'h300, 0, 32'hC4,  1,  1, 32'h200,   1, 32'h300, 6);
    tbl[14] = mk(32'hC0,     0, 0,       0, 0,       0, 0,       0,  0, 32'hC4,    0, 32'h300, 6);
    tbl[15] = mk(32'h80,     0, 0,       0, 0,       0, 0,       0,  0, 32'h84,    0, 32'h300, 6);
    tbl[16] = mk(32'h1000,   1, 32'h1000,1, 32'h2000,1, 32'h3000,0,  0, 32'h1004,  1, 32'h2000,7);
    tbl[17] = mk(32'h1000,   0, 0,       0, 0,       0, 0,       0,  1, 32'h2000,  0, 32'h2000,7);
    tbl[18] = mk(32'hFFFFFFFC,0,0,       0, 0,       0, 0,       0,  0, 32'h0,     0, 32'h2000,7);

    m_reset();
    repeat (2) @(negedge CLK);
    chk("reset_mispredict", 32'(mispredict), 32'h0);
    chk("reset_redirect", redirect_pc, 32'h0);
    chk("reset_cnt", 32'(mispredict_cnt), 32'h0);
    nRST = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].f, tbl[i].ue, tbl[i].up, tbl[i].ut, tbl[i].utg, tbl[i].upt, tbl[i].upn, tbl[i].fl);
      chk($sformatf("v%0d_pred_taken", i), 32'(pred_taken), 32'(tbl[i].ept));
      chk($sformatf("v%0d_pred_npc", i), pred_npc, tbl[i].enpc);
      chk($sformatf("v%0d_pred_npc_small", i), pred_npc2, tbl[i].enpc);
      tick();
      chk($sformatf("v%0d_mispredict", i), 32'(mispredict), 32'(tbl[i].emis));
      chk($sformatf("v%0d_redirect", i), redirect_pc, tbl[i].ered);
      chk($sformatf("v%0d_cnt", i), 32'(mispredict_cnt), 32'(tbl[i].ecnt));
      chk($sformatf("v%0d_cnt_sat", i), 32'(mispredict_cnt2), 32'((tbl[i].ecnt > 3) ? 3 : tbl[i].ecnt));
    end

    // Reset mid-stream with a wrong, allocating update pending.
    drive(32'h40, 1, 32'h40, 1, 32'h500, 0, 32'h44, 0);
    #2 nRST = 1'b0;
    #1;
    chk("midrst_mispredict", 32'(mispredict), 32'h0);
    chk("midrst_cnt", 32'(mispredict_cnt), 32'h0);
    chk("midrst_cnt_small", 32'(mispredict_cnt2), 32'h0);
    chk("midrst_redirect", redirect_pc, 32'h0);
    @(posedge CLK); #1;
    chk("midrst_hold_cnt", 32'(mispredict_cnt), 32'h0);
    @(negedge CLK);
    upd_en = 1'b0;
    nRST = 1'b1;
    m_reset();
    foreach (tbl[i]) begin
      fetch_pc = tbl[i].f;
      #1;
      chk($sformatf("midrst_miss_%0d", i), 32'(pred_taken), 32'h0);
    end
    fetch_pc = 32'h40;
    #1;
    chk("midrst_npc", pred_npc, 32'h44);

    // Random traffic over a small PC/target pool so hits, aliasing and saturation occur.
    for (int n = 0; n < 600; n++) begin
      f   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      up  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      ue  = ($urandom_range(0, 3) != 0);
      ut  = ($urandom_range(0, 1) != 0);
      utg = 32'($urandom_range(1, 6)) << 8;
      fl  = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) != 0) begin
        m_lookup(up, upt, upn);
      end else begin
        upt = ($urandom_range(0, 1) != 0);
        upn = ($urandom_range(0, 1) != 0) ? utg : up + 32'd4;
      end
      drive(f, ue, up, ut, utg, upt, upn, fl);
      m_lookup(f, t, npc);
      chk("rnd_pred_taken", 32'(pred_taken), 32'(t));
      chk("rnd_pred_npc", pred_npc, npc);
      chk("rnd_pred_taken_small", 32'(pred_taken2), 32'(t));
      tick();
      chk("rnd_mispredict", 32'(mispredict), 32'(m_mis));
      chk("rnd_redirect", redirect_pc, m_redir);
      chk("rnd_cnt", 32'(mispredict_cnt), 32'(m_cnt));
      chk("rnd_cnt_small", 32'(mispredict_cnt2), 32'(m_cnt2));
      chk("rnd_mispredict_small", 32'(mispredict2), 32'(m_mis));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
